// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - RV32 instruction fetch stage: one outstanding imem read, valid/ready to decode, redirects
module ifu_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h80000000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    input  logic             imem_resp_err,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_fault,
    output logic [WIDTH-1:0] debug_pc,
    output logic [WIDTH-1:0] debug_inst
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic             drop;
    logic [WIDTH-1:0] inst_r;
    logic             fault_r;
    logic             aligned;
    logic             req_fire;
    logic             retire;

    assign aligned  = (pc[1:0] == 2'b00);
    assign req_fire = imem_req_valid && imem_req_ready;
    assign retire   = inst_valid && inst_ready;

    // Request and decode-side outputs; a misaligned pc never reaches memory
    always_comb begin
        imem_req_valid = (state == ST_REQ) && aligned;
        imem_addr      = pc;
        inst_valid     = (state == ST_OUT) && !redirect_valid;
        inst           = inst_r;
        inst_pc        = pc;
        inst_fault     = fault_r;
    end

    // Next-state selection; a redirect overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (req_fire) begin
                    state_next = ST_WAIT;
                end else if (!redirect_valid && !aligned) begin
                    state_next = ST_OUT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_next = (drop || redirect_valid) ? ST_REQ : ST_OUT;
                end
            end
            ST_OUT: begin
                if (redirect_valid || inst_ready) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding memory response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, drop flag, held instruction and debug trace
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst_r     <= '0;
            fault_r    <= 1'b0;
            debug_pc   <= RESET_PC;
            debug_inst <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (req_fire) begin
                            drop <= 1'b1;
                        end
                    end else if (!aligned) begin
                        inst_r  <= '0;
                        fault_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        drop <= 1'b0;
                        if (redirect_valid) begin
                            pc <= redirect_pc;
                        end else if (!drop) begin
                            inst_r  <= imem_resp_err ? '0 : imem_resp_data;
                            fault_r <= imem_resp_err;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                        pc   <= redirect_pc;
                    end
                end
                ST_OUT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (retire) begin
                        pc         <= pc + WIDTH'(4);
                        debug_pc   <= pc;
                        debug_inst <= inst_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
